// File: rtl/mem_arbiter_n.sv
// rtl/mem_arbiter_n.sv - N-requester arbiter in front of a single-outstanding memory controller.
// One command is latched, issued, waited on, then completed with a one-hot pulse.
module mem_arbiter_n #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 64,
  parameter int BLOCKSZ = 512,
  parameter int RR_MODE = 1,
  parameter int GIDX_W  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           wr_en,
  input  logic [NREQ*ADDR_W-1:0]    addr_in,
  input  logic [NREQ*BLOCKSZ-1:0]   data_in,
  output logic [BLOCKSZ-1:0]        data_out,
  output logic [NREQ-1:0]           complete,
  output logic                      busy,
  output logic [GIDX_W-1:0]         grant_idx,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [BLOCKSZ-1:0]        mem_data_out,
  output logic                      mem_req,
  output logic                      mem_wr_en,
  input  logic [BLOCKSZ-1:0]        data_from_mem,
  input  logic                      mem_data_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [GIDX_W-1:0]   grant_q, grant_d;
  logic [GIDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BLOCKSZ-1:0]  wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [BLOCKSZ-1:0]  rdata_q, rdata_d;

  logic [GIDX_W-1:0]   win_lo, win_hi, winner;
  logic                found_hi;

  // Lowest set index overall, and lowest set index at or above rr_ptr (round-robin wrap).
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    found_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_lo = GIDX_W'(i);
        if (GIDX_W'(i) >= rr_ptr_q) begin
          win_hi   = GIDX_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    winner = ((RR_MODE != 0) && found_hi) ? win_hi : win_lo;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_ISSUE;
          grant_d = winner;
          for (int i = 0; i < NREQ; i++) begin
            if (GIDX_W'(i) == winner) begin
              addr_d  = addr_in[i*ADDR_W +: ADDR_W];
              wdata_d = data_in[i*BLOCKSZ +: BLOCKSZ];
              wr_d    = wr_en[i];
            end
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_data_valid) begin
          state_d = S_DONE;
          if (!wr_q) rdata_d = data_from_mem;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (RR_MODE != 0) begin
          rr_ptr_d = (grant_q == GIDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    complete = '0;
    for (int i = 0; i < NREQ; i++) begin
      complete[i] = (state_q == S_DONE) && (grant_q == GIDX_W'(i));
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign mem_req      = (state_q == S_ISSUE);
  assign grant_idx    = grant_q;
  assign mem_address  = addr_q;
  assign mem_data_out = wdata_q;
  assign mem_wr_en    = wr_q;
  assign data_out     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb/tb_mem_arbiter_n.sv - directed self-checking bench for mem_arbiter_n.
module tb_mem_arbiter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: NREQ=2, round-robin, default widths
  logic [1:0]    a_req, a_wr, a_cmp;
  logic [127:0]  a_addr;
  logic [1023:0] a_din;
  logic [511:0]  a_dout, a_mdo, a_dfm;
  logic          a_busy, a_mreq, a_mwr, a_mdv;
  logic [0:0]    a_gidx;
  logic [63:0]   a_maddr;

  // B: NREQ=3 round-robin; C: NREQ=3 fixed priority
  logic [2:0]  b_req, b_wr, b_cmp, c_req, c_wr, c_cmp;
  logic [47:0] b_addr, c_addr;
  logic [95:0] b_din, c_din;
  logic [31:0] b_dout, b_mdo, b_dfm, c_dout, c_mdo, c_dfm;
  logic        b_busy, b_mreq, b_mwr, b_mdv, c_busy, c_mreq, c_mwr, c_mdv;
  logic [1:0]  b_gidx, c_gidx;
  logic [15:0] b_maddr, c_maddr;

  mem_arbiter_n #(.NREQ(2)) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .wr_en(a_wr), .addr_in(a_addr), .data_in(a_din),
    .data_out(a_dout), .complete(a_cmp), .busy(a_busy), .grant_idx(a_gidx),
    .mem_address(a_maddr), .mem_data_out(a_mdo), .mem_req(a_mreq), .mem_wr_en(a_mwr),
    .data_from_mem(a_dfm), .mem_data_valid(a_mdv)
  );

  mem_arbiter_n #(.NREQ(3), .ADDR_W(16), .BLOCKSZ(32), .RR_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .wr_en(b_wr), .addr_in(b_addr), .data_in(b_din),
    .data_out(b_dout), .complete(b_cmp), .busy(b_busy), .grant_idx(b_gidx),
    .mem_address(b_maddr), .mem_data_out(b_mdo), .mem_req(b_mreq), .mem_wr_en(b_mwr),
    .data_from_mem(b_dfm), .mem_data_valid(b_mdv)
  );

  mem_arbiter_n #(.NREQ(3), .ADDR_W(16), .BLOCKSZ(32), .RR_MODE(0)) dut_c (
    .clk(clk), .rst(rst), .req(c_req), .wr_en(c_wr), .addr_in(c_addr), .data_in(c_din),
    .data_out(c_dout), .complete(c_cmp), .busy(c_busy), .grant_idx(c_gidx),
    .mem_address(c_maddr), .mem_data_out(c_mdo), .mem_req(c_mreq), .mem_wr_en(c_mwr),
    .data_from_mem(c_dfm), .mem_data_valid(c_mdv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction on B and C in lockstep; B's granted requester drops req for one IDLE cycle.
  task automatic txn_bc(input int gb, input int gc);
    tick();
    b_req = 3'b111;
    chk("b_gidx", 512'(b_gidx), 512'(gb));
    chk("b_mreq", 512'(b_mreq), 512'(1));
    chk("b_maddr", 512'(b_maddr), 512'('h100 * (gb + 1)));
    chk("c_gidx", 512'(c_gidx), 512'(gc));
    chk("c_maddr", 512'(c_maddr), 512'('h100 * (gc + 1)));
    tick();
    b_mdv = 1'b1;
    c_mdv = 1'b1;
    tick();
    b_mdv = 1'b0;
    c_mdv = 1'b0;
    chk("b_complete", 512'(b_cmp), 512'(1 << gb));
    chk("c_complete", 512'(c_cmp), 512'(1 << gc));
    chk("b_dout", 512'(b_dout), 512'(32'hB0B0B0B0));
    chk("c_mwr", 512'(c_mwr), 512'(0));
    tick();
    chk("b_busy_idle", 512'(b_busy), 512'(0));
    chk("c_busy_idle", 512'(c_busy), 512'(0));
    b_req = b_req & ~(3'b001 << gb);
  endtask

  initial begin
    rst = 1'b1;
    a_req = '0; a_wr = '0; a_addr = '0; a_din = '0; a_dfm = '0; a_mdv = 1'b0;
    b_req = '0; b_wr = '0; b_din = '0; b_dfm = 32'hB0B0B0B0; b_mdv = 1'b0;
    c_req = '0; c_wr = '0; c_din = '0; c_dfm = 32'hC0C0C0C0; c_mdv = 1'b0;
    b_addr = {16'h0300, 16'h0200, 16'h0100};
    c_addr = {16'h0300, 16'h0200, 16'h0100};
    tick();
    tick();
    chk("rst_busy", 512'(a_busy), 512'(0));
    chk("rst_complete", 512'(a_cmp), 512'(0));
    chk("rst_mem_req", 512'(a_mreq), 512'(0));
    chk("rst_dout", a_dout, 512'(0));
    chk("rst_maddr", 512'(a_maddr), 512'(0));
    chk("rst_b_busy", 512'(b_busy), 512'(0));

    // Read on A, aborted by reset while waiting on memory
    rst = 1'b0;
    a_addr[63:0] = 64'h1000;
    a_req = 2'b01;
    tick();
    chk("abort_mem_req", 512'(a_mreq), 512'(1));
    chk("abort_maddr", 512'(a_maddr), 512'(64'h1000));
    tick();
    chk("abort_wait_mreq", 512'(a_mreq), 512'(0));
    chk("abort_wait_busy", 512'(a_busy), 512'(1));
    #1 rst = 1'b1;
    #1;
    chk("async_busy", 512'(a_busy), 512'(0));
    chk("async_maddr", 512'(a_maddr), 512'(0));
    chk("async_complete", 512'(a_cmp), 512'(0));
    tick();
    chk("abort_no_complete", 512'(a_cmp), 512'(0));
    rst = 1'b0;

    // Held request re-issues, then completes as a single read
    tick();
    chk("reissue_mem_req", 512'(a_mreq), 512'(1));
    chk("reissue_maddr", 512'(a_maddr), 512'(64'h1000));
    tick();
    chk("read_wait_mreq", 512'(a_mreq), 512'(0));
    tick();
    a_dfm = {16{32'hA5A5A5A5}};
    a_mdv = 1'b1;
    tick();
    a_mdv = 1'b0;
    chk("read_complete", 512'(a_cmp), 512'(2'b01));
    chk("read_dout", a_dout, {16{32'hA5A5A5A5}});
    chk("read_busy_done", 512'(a_busy), 512'(1));
    tick();
    chk("read_busy_after", 512'(a_busy), 512'(0));
    chk("read_complete_off", 512'(a_cmp), 512'(0));

    // Write from requester 1
    a_req = 2'b10;
    a_wr = 2'b10;
    a_addr[127:64] = 64'h2040;
    a_din[1023:512] = {16{32'hDEADBEEF}};
    tick();
    chk("wr_mem_req", 512'(a_mreq), 512'(1));
    chk("wr_gidx", 512'(a_gidx), 512'(1));
    chk("wr_mem_wr_en", 512'(a_mwr), 512'(1));
    chk("wr_maddr", 512'(a_maddr), 512'(64'h2040));
    chk("wr_mdo", a_mdo, {16{32'hDEADBEEF}});
    tick();
    a_dfm = {16{32'h5A5A5A5A}};
    a_mdv = 1'b1;
    tick();
    a_mdv = 1'b0;
    chk("wr_complete", 512'(a_cmp), 512'(2'b10));
    chk("wr_dout_kept", a_dout, {16{32'hA5A5A5A5}});
    tick();
    chk("wr_busy_after", 512'(a_busy), 512'(0));

    // Spurious valid in IDLE and ISSUE, then requester drops req mid-transaction
    a_req = 2'b00;
    a_wr = 2'b00;
    a_mdv = 1'b1;
    tick();
    chk("spur_idle_busy", 512'(a_busy), 512'(0));
    chk("spur_idle_complete", 512'(a_cmp), 512'(0));
    a_mdv = 1'b0;
    a_req = 2'b01;
    a_addr[63:0] = 64'h3000;
    tick();
    chk("spur_mem_req", 512'(a_mreq), 512'(1));
    chk("spur_gidx", 512'(a_gidx), 512'(0));
    a_mdv = 1'b1;
    tick();
    chk("spur_issue_complete", 512'(a_cmp), 512'(0));
    chk("spur_issue_busy", 512'(a_busy), 512'(1));
    a_mdv = 1'b0;
    a_req = 2'b00;
    tick();
    chk("drop_still_wait", 512'(a_busy), 512'(1));
    chk("drop_no_complete", 512'(a_cmp), 512'(0));
    a_dfm = {16{32'h3C3C3C3C}};
    a_mdv = 1'b1;
    tick();
    a_mdv = 1'b0;
    chk("drop_complete", 512'(a_cmp), 512'(2'b01));
    chk("drop_dout", a_dout, {16{32'h3C3C3C3C}});
    tick();
    chk("drop_busy_after", 512'(a_busy), 512'(0));

    // Round-robin on B (0,1,2,0,1,2) alongside fixed priority on C (1,1 then 2 after 1 drops)
    b_req = 3'b111;
    c_req = 3'b110;
    txn_bc(0, 1);
    txn_bc(1, 1);
    c_req = 3'b100;
    txn_bc(2, 2);
    txn_bc(0, 2);
    txn_bc(1, 2);
    txn_bc(2, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
- Parametrised N-requester arbiter between the L1 caches (icache, dcache, future MMU walker/prefetcher) and the single-outstanding memory controller.
- Latches one requester's command, issues it to the memory controller, waits for completion, then routes the read block back with a per-requester completion pulse.
- Supports read and write, round-robin or fixed-priority selection, and any requester count ≥2.

Parameters:
- NREQ, 2, number of requesters (≥2).
- ADDR_W, 64, address width.
- BLOCKSZ, 512, cache block width in bits.
- RR_MODE, 1, 1 = round-robin; 0 = fixed priority (lowest index wins).
- GIDX_W, $clog2(NREQ), grant index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  NREQ  per-requester request level.
- wr_en  input  NREQ  per-requester write flag (1 = write block, 0 = read block).
- addr_in  input  NREQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- data_in  input  NREQ*BLOCKSZ  flattened write data; requester i at [i*BLOCKSZ +: BLOCKSZ].
- data_out  output  BLOCKSZ  read block, shared by all requesters.
- complete  output  NREQ  one-hot completion pulse.
- busy  output  1  high while a transaction is in flight (state ≠ IDLE).
- grant_idx  output  GIDX_W  index of the current or last granted requester.
- mem_address  output  ADDR_W  to memory controller.
- mem_data_out  output  BLOCKSZ  write data to memory controller.
- mem_req  output  1  start pulse to memory controller.
- mem_wr_en  output  1  write qualifier, valid while busy.
- data_from_mem  input  BLOCKSZ  read data from memory controller.
- mem_data_valid  input  1  memory operation done; data_from_mem valid this cycle.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = 0. Reset asserted mid-transaction aborts it; no complete pulse is issued.
- States:
  - IDLE → ISSUE when any req bit is set.
  - ISSUE → WAIT unconditionally.
  - WAIT → DONE when mem_data_valid = 1.
  - DONE → IDLE unconditionally.
- IDLE selection:
  - RR_MODE = 1: first set req bit searching from rr_ptr upward, wrapping NREQ-1 → 0.
  - RR_MODE = 0: lowest set index.
  - On the IDLE → ISSUE edge, latch grant_idx, mem_address, mem_data_out and mem_wr_en from the winner's slices.
- ISSUE: mem_req = 1 for exactly one cycle. Latched command fields are held stable until the next grant.
- mem_data_valid handling:
  - Sampled only in WAIT. Assertions in IDLE, ISSUE or DONE are ignored.
  - Memory controller latency is ≥1 cycle after the mem_req pulse.
- WAIT → DONE edge:
  - For a read, latch data_from_mem into data_out.
  - For a write, data_out keeps its previous value.
- DONE:
  - complete[grant_idx] = 1 for exactly one cycle; all other complete bits are 0.
  - If RR_MODE = 1, rr_ptr ← (grant_idx + 1) mod NREQ, i.e. wraps to 0 when grant_idx = NREQ-1.
- data_out holds its value until the next read completion.
- Protocol rules:
  - Requesters hold req, addr_in and data_in until their complete pulse, and drop req the cycle after it.
  - The DONE → IDLE bubble guarantees a still-high req in the DONE cycle is not re-granted for the same transaction.
- Requester deasserts req mid-transaction: the transaction still completes and its complete pulse is still issued.
- Requests arriving while busy are not lost: they wait at level and are arbitrated in the next IDLE cycle.
- Back-to-back throughput: one transaction per (memory latency + 3) cycles.
- Starvation: with RR_MODE = 1, a continuously asserted requester is granted within NREQ transactions.
- NREQ not a power of two: rr_ptr wraps at NREQ, not at 2^GIDX_W. Out-of-range indices are never granted.

Test Plan:
- Reset mid-transaction: NREQ=2; req=2'b01, read addr 0x1000, controller returns 0xA5-pattern after 3 cycles; apply rst in WAIT → all outputs 0 asynchronously, no complete pulse; after release, the held req re-issues to mem_address 0x1000.
- Single read: NREQ=2; req=2'b01, read addr 0x1000, controller returns 0xA5-pattern after 3 cycles → mem_req pulse 1 cycle after req; complete=2'b01 one cycle after mem_data_valid; data_out = 0xA5-pattern; busy low the cycle after complete.
- Write: req=2'b10, wr_en=2'b10, addr 0x2040, data 0xDEADBEEF-pattern → mem_wr_en=1, mem_address=0x2040, mem_data_out matches; complete=2'b10; data_out unchanged from prior read.
- Round-robin contention: NREQ=3, RR_MODE=1; all req held high, each dropped one cycle after its complete and reasserted → grants 0,1,2,0,1,2; rr_ptr wraps 2→0.
- Fixed priority: NREQ=3, RR_MODE=0; req=3'b110 held → grant 1 repeatedly; requester 2 granted only after requester 1 drops req.
- Spurious valid: mem_data_valid pulsed while IDLE and during ISSUE → ignored, no complete; a mid-transaction req drop still yields a complete pulse.
